// File: rtl/i2s_ser_pkg.sv
// Shared I2S types and constants: sample-width enum, frame geometry, serializer FSM states.
// Also holds the per-channel width mask applied when a frame is loaded.
package i2s_ser_pkg;

   localparam int unsigned I2S_FRAME_BITS = 64;
   localparam int unsigned I2S_SLOT_BITS  = 32;

   typedef enum logic [1:0] {
      B16 = 2'd0,
      B24 = 2'd1,
      B32 = 2'd2
   } bitnum_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } i2s_ser_state_e;

   // Zero the unused LSBs of each MSB-aligned channel half.
   function automatic logic [I2S_FRAME_BITS-1:0] i2s_mask(
      input logic [I2S_FRAME_BITS-1:0] i_d,
      input bitnum_e                   i_bn
   );
      logic [I2S_SLOT_BITS-1:0] w_m;
      case (i_bn)
         B16:     w_m = 32'hFFFF_0000;
         B24:     w_m = 32'hFFFF_FF00;
         default: w_m = 32'hFFFF_FFFF;
      endcase
      return i_d & {w_m, w_m};
   endfunction

endpackage

// File: rtl/i2s_bck_gen.sv
// I2S bit-clock generator: divides the master clock into BCK and flags the BCK falling edge.
// o_fall is high in the clk cycle whose rising edge produces the BCK falling edge.
module i2s_bck_gen #(
   parameter int unsigned MCLK_PER_BCK = 4
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_run,
   output logic o_bck,
   output logic o_fall
);

   localparam int unsigned DIV_W = (MCLK_PER_BCK > 1) ? $clog2(MCLK_PER_BCK) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MCLK_PER_BCK - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(MCLK_PER_BCK / 2);

   logic [DIV_W-1:0] r_div_cnt;
   logic [DIV_W-1:0] w_div_nxt;
   logic             r_bck;

   always_comb begin
      w_div_nxt = '0;
      if (i_run && (r_div_cnt != DIV_LAST)) begin
         w_div_nxt = r_div_cnt + DIV_W'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_div_cnt <= '0;
         r_bck     <= 1'b0;
      end else begin
         r_div_cnt <= w_div_nxt;
         r_bck     <= (w_div_nxt >= DIV_HALF);
      end
   end

   assign o_bck  = r_bck;
   assign o_fall = i_run && (r_div_cnt == DIV_LAST);

endmodule

// File: rtl/i2s_ser.sv
// I2S master transmitter: one-entry holding buffer feeding a 64-slot frame shifter.
// Optional macro I2S_SER_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module i2s_ser
   import i2s_ser_pkg::*;
#(
   parameter int unsigned MCLK_PER_BCK = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  bitnum_e                   bitnum,
   input  logic [I2S_FRAME_BITS-1:0] in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic                      i2s_bck,
   output logic                      i2s_lrck,
   output logic                      i2s_data,
   output logic                      frame_start,
`ifdef I2S_SER_UNDERRUN_CNT_EN
   output logic                      underrun,
   output logic [15:0]               underrun_cnt
`else
   output logic                      underrun
`endif
);

   localparam int unsigned BIT_W = $clog2(I2S_FRAME_BITS);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(I2S_FRAME_BITS - 1);
   localparam logic [BIT_W-1:0] LR_FIRST = BIT_W'(I2S_SLOT_BITS - 1);

   i2s_ser_state_e            r_state;
   i2s_ser_state_e            w_state_nxt;
   logic [I2S_FRAME_BITS-1:0] r_buf;
   logic [I2S_FRAME_BITS-1:0] w_buf_nxt;
   logic                      r_buf_full;
   logic                      w_buf_full_nxt;
   logic                      r_in_ready;
   logic [I2S_FRAME_BITS-1:0] r_shift;
   logic [I2S_FRAME_BITS-1:0] w_shift_nxt;
   logic [BIT_W-1:0]          r_bit_cnt;
   logic [BIT_W-1:0]          w_bit_cnt_nxt;
   logic                      r_lrck;
   logic                      w_lrck_nxt;
   logic                      r_data;
   logic                      w_data_nxt;
   logic                      r_frame_start;
   logic                      w_frame_start_nxt;
   logic                      r_underrun;
   logic                      w_underrun_nxt;
   logic                      w_xfer;
   logic                      w_run;
   logic                      w_fall;
   logic                      w_bck;

   assign w_run  = (r_state == RUN);
   assign w_xfer = in_valid && r_in_ready;

   i2s_bck_gen #(
      .MCLK_PER_BCK(MCLK_PER_BCK)
   ) u_bck_gen (
      .i_clk  (clk),
      .i_reset(reset),
      .i_run  (w_run),
      .o_bck  (w_bck),
      .o_fall (w_fall)
   );

   always_comb begin
      w_state_nxt       = r_state;
      w_buf_nxt         = r_buf;
      w_buf_full_nxt    = r_buf_full;
      w_shift_nxt       = r_shift;
      w_bit_cnt_nxt     = r_bit_cnt;
      w_lrck_nxt        = r_lrck;
      w_data_nxt        = r_data;
      w_frame_start_nxt = 1'b0;
      w_underrun_nxt    = 1'b0;

      // Accepting only when empty keeps a transfer and a load from ever colliding.
      if (w_xfer) begin
         w_buf_nxt      = in_data;
         w_buf_full_nxt = 1'b1;
      end

      case (r_state)
         IDLE: begin
            w_bit_cnt_nxt = LAST_BIT;
            w_lrck_nxt    = 1'b0;
            w_data_nxt    = 1'b0;
            if (enable && r_buf_full) begin
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (w_fall) begin
               if (r_bit_cnt == LAST_BIT) begin
                  if (!enable) begin
                     w_state_nxt = IDLE;
                     w_lrck_nxt  = 1'b0;
                     w_data_nxt  = 1'b0;
                  end else begin
                     w_bit_cnt_nxt = '0;
                     w_lrck_nxt    = 1'b0;
                     if (r_buf_full) begin
                        w_shift_nxt       = i2s_mask(r_buf, bitnum);
                        w_buf_full_nxt    = 1'b0;
                        w_frame_start_nxt = 1'b1;
                     end else begin
                        w_shift_nxt    = '0;
                        w_underrun_nxt = 1'b1;
                     end
                     w_data_nxt = w_shift_nxt[I2S_FRAME_BITS-1];
                  end
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
                  // Slot k carries shifter bit 63-k, i.e. the bitwise inverse of k.
                  w_data_nxt    = r_shift[~w_bit_cnt_nxt];
                  w_lrck_nxt    = (w_bit_cnt_nxt >= LR_FIRST) && (w_bit_cnt_nxt != LAST_BIT);
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_buf         <= '0;
         r_buf_full    <= 1'b0;
         r_in_ready    <= 1'b1;
         r_shift       <= '0;
         r_bit_cnt     <= LAST_BIT;
         r_lrck        <= 1'b0;
         r_data        <= 1'b0;
         r_frame_start <= 1'b0;
         r_underrun    <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_buf         <= w_buf_nxt;
         r_buf_full    <= w_buf_full_nxt;
         r_in_ready    <= !w_buf_full_nxt;
         r_shift       <= w_shift_nxt;
         r_bit_cnt     <= w_bit_cnt_nxt;
         r_lrck        <= w_lrck_nxt;
         r_data        <= w_data_nxt;
         r_frame_start <= w_frame_start_nxt;
         r_underrun    <= w_underrun_nxt;
      end
   end

`ifdef I2S_SER_UNDERRUN_CNT_EN
   logic        r_enable_prev;
   logic [15:0] r_underrun_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_enable_prev  <= 1'b0;
         r_underrun_cnt <= '0;
      end else begin
         r_enable_prev <= enable;
         if (enable && !r_enable_prev) begin
            r_underrun_cnt <= '0;
         end else if (w_underrun_nxt && (r_underrun_cnt != 16'hFFFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
         end
      end
   end

   assign underrun_cnt = r_underrun_cnt;
`endif

   assign in_ready    = r_in_ready;
   assign i2s_bck     = w_bck;
   assign i2s_lrck    = r_lrck;
   assign i2s_data    = r_data;
   assign frame_start = r_frame_start;
   assign underrun    = r_underrun;

endmodule

// File: tb/tb_i2s_ser.sv
// Scoreboard bench for i2s_ser: stimulus queues expected frames, a monitor rebuilds each
// serialized frame from BCK falling edges and compares data and LRCK against the queue.
module tb_i2s_ser;
   import i2s_ser_pkg::*;

   localparam int unsigned MCLK_PER_BCK = 4;
   // LRCK captured MSB-first over slots 0..63: high for slots 31..62.
   localparam logic [63:0] LRCK_PAT = 64'h0000_0001_FFFF_FFFE;
`ifdef I2S_SER_UNDERRUN_CNT_EN
   localparam int EXP_FS = 5;
   localparam int EXP_UR = 4;
`else
   localparam int EXP_FS = 4;
   localparam int EXP_UR = 1;
`endif

   typedef struct packed {
      logic [63:0] data;
      logic        ur;
   } exp_t;

   logic        clk      = 1'b0;
   logic        reset    = 1'b1;
   logic        enable   = 1'b0;
   bitnum_e     bitnum   = B32;
   logic [63:0] in_data  = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        i2s_bck;
   logic        i2s_lrck;
   logic        i2s_data;
   logic        frame_start;
   logic        underrun;
`ifdef I2S_SER_UNDERRUN_CNT_EN
   logic [15:0] underrun_cnt;
`endif

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_fs  = 0;
   int   n_ur  = 0;

   i2s_ser #(
      .MCLK_PER_BCK(MCLK_PER_BCK)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .bitnum      (bitnum),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .i2s_bck     (i2s_bck),
      .i2s_lrck    (i2s_lrck),
      .i2s_data    (i2s_data),
      .frame_start (frame_start),
`ifdef I2S_SER_UNDERRUN_CNT_EN
      .underrun    (underrun),
      .underrun_cnt(underrun_cnt)
`else
      .underrun    (underrun)
`endif
   );

   always #5 clk = ~clk;

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, want %b", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One-cycle transfer; expected (masked) frame goes to the scoreboard.
   task automatic send(input logic [63:0] d, input logic [63:0] exp);
      exp_t e;
      int   n = 0;
      while (!in_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check1("in_ready before send", in_ready, 1'b1);
      if (in_ready) begin
         e.data = exp;
         e.ur   = 1'b0;
         sb_q.push_back(e);
         in_valid = 1'b1;
         in_data  = d;
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic push_silence();
      exp_t e;
      e.data = '0;
      e.ur   = 1'b1;
      sb_q.push_back(e);
   endtask

   task automatic wait_fs(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (frame_start !== 1'b1 && n < 2000);
      check1(name, frame_start, 1'b1);
   endtask

   // Monitor: frames begin on frame_start/underrun and collect one bit per BCK fall.
   initial begin
      logic        prev_bck = 1'b0;
      logic        fell;
      logic [63:0] cap = '0;
      logic [63:0] lr  = '0;
      int          cnt = 0;
      bit          active = 1'b0;
      exp_t        cur;
      forever begin
         @(negedge clk);
         if (reset) begin
            active   = 1'b0;
            cnt      = 0;
            prev_bck = 1'b0;
         end else begin
            fell = prev_bck && !i2s_bck;
            if (frame_start || underrun) begin
               if (frame_start) n_fs++;
               if (underrun) n_ur++;
               check1("frame boundary on bck fall", fell, 1'b1);
               if (active) check64("frame truncated (bits seen)", 64'(cnt), 64'd64);
               n_cmp++;
               if (sb_q.size() == 0) begin
                  n_err++;
                  active = 1'b0;
                  $display("FAIL unexpected frame: got underrun=%0b, want no frame", underrun);
               end else begin
                  cur = sb_q.pop_front();
                  check1("frame kind (1=underrun)", underrun, cur.ur);
                  cap    = {63'd0, i2s_data};
                  lr     = {63'd0, i2s_lrck};
                  cnt    = 1;
                  active = 1'b1;
               end
            end else if (fell && active) begin
               cap = {cap[62:0], i2s_data};
               lr  = {lr[62:0], i2s_lrck};
               cnt++;
               if (cnt == 64) begin
                  check64("frame data", cap, cur.data);
                  check64("frame lrck", lr, LRCK_PAT);
                  active = 1'b0;
               end
            end
            prev_bck = i2s_bck;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tick(2);
      check1("reset bck", i2s_bck, 1'b0);
      check1("reset lrck", i2s_lrck, 1'b0);
      check1("reset data", i2s_data, 1'b0);
      check1("reset in_ready", in_ready, 1'b1);
      check1("reset frame_start", frame_start, 1'b0);
      check1("reset underrun", underrun, 1'b0);
      reset = 1'b0;
      tick(1);

      // b32 frame, then a b16 frame queued back-to-back during it
      enable = 1'b1;
      bitnum = B32;
      send(64'hA5A5_0000_0000_5A5A, 64'hA5A5_0000_0000_5A5A);
      check1("in_ready low after transfer", in_ready, 1'b0);
      wait_fs("frame 1 start");
      check1("in_ready after load", in_ready, 1'b1);
      bitnum = B16;
      send(64'h1234_FFFF_ABCD_FFFF, 64'h1234_0000_ABCD_0000);
      tick(255);
      check1("frame 2 starts 256 clk later", frame_start, 1'b1);
      check1("no underrun between full frames", underrun, 1'b0);

      // buffer a b24 sample, drop enable at slot 10; bitnum change applies at next load
      send(64'hDEAD_BEEF_0123_4567, 64'hDEAD_BE00_0123_4500);
      tick(39);
      enable = 1'b0;
      bitnum = B24;
      tick(83);
      check1("lrck low at slot 30", i2s_lrck, 1'b0);
      tick(1);
      check1("lrck high at slot 31", i2s_lrck, 1'b1);
      tick(4);
      check1("right MSB 4 clk after lrck edge", i2s_data, 1'b1);
      tick(128);
      check1("idle bck", i2s_bck, 1'b0);
      check1("idle lrck", i2s_lrck, 1'b0);
      check1("idle data", i2s_data, 1'b0);
      check1("idle buffer held", in_ready, 1'b0);
      check1("idle no frame_start", frame_start, 1'b0);
      tick(20);
      check1("idle bck stays low", i2s_bck, 1'b0);
      check1("idle buffer still held", in_ready, 1'b0);
      check64("frame_start count after idle", 64'(n_fs), 64'd2);

      // re-enable: held sample plays, then one silent underrun frame
      push_silence();
      enable = 1'b1;
      wait_fs("frame 3 start");
      tick(256);
      check1("underrun at 256 clk after load", underrun, 1'b1);
      tick(1);
      check1("underrun is one pulse", underrun, 1'b0);
      tick(1);
      check1("bck runs during silence", i2s_bck, 1'b1);
      enable = 1'b0;
      tick(254);
      check1("idle bck after silence", i2s_bck, 1'b0);
      check1("idle lrck after silence", i2s_lrck, 1'b0);
      check64("underrun count", 64'(n_ur), 64'd1);

      // asynchronous reset mid-frame at slot 40 with a buffered sample
      bitnum = B32;
      enable = 1'b1;
      send(64'hFFFF_FFFF_8000_0001, 64'hFFFF_FFFF_8000_0001);
      wait_fs("frame 4 start");
      send(64'h0F0F_0F0F_0F0F_0F0F, 64'h0F0F_0F0F_0F0F_0F0F);
      tick(161);
      check1("slot 40 lrck before reset", i2s_lrck, 1'b1);
      check1("slot 40 bck before reset", i2s_bck, 1'b1);
      check1("buffer full before reset", in_ready, 1'b0);
      #2 reset = 1'b1;
      #1;
      check1("async reset bck", i2s_bck, 1'b0);
      check1("async reset lrck", i2s_lrck, 1'b0);
      check1("async reset data", i2s_data, 1'b0);
      check1("async reset in_ready", in_ready, 1'b1);
      check1("async reset frame_start", frame_start, 1'b0);
      sb_q.delete();
      tick(2);
      reset = 1'b0;
      tick(10);
      check1("idle after reset, empty buffer", i2s_bck, 1'b0);
      enable = 1'b0;

`ifdef I2S_SER_UNDERRUN_CNT_EN
      tick(2);
      enable = 1'b1;
      send(64'h0000_0001_0000_0002, 64'h0000_0001_0000_0002);
      push_silence();
      push_silence();
      push_silence();
      wait_fs("frame 5 start");
      tick(800);
      enable = 1'b0;
      tick(224);
      check64("underrun_cnt after 3 starved frames", 64'(underrun_cnt), 64'd3);
      check1("idle after starved frames", i2s_bck, 1'b0);
      tick(2);
      enable = 1'b1;
      tick(2);
      check64("underrun_cnt cleared by enable rise", 64'(underrun_cnt), 64'd0);
      enable = 1'b0;
`endif

      tick(4);
      check64("scoreboard drained", 64'(sb_q.size()), 64'd0);
      check64("total frame_start", 64'(n_fs), 64'(EXP_FS));
      check64("total underrun", 64'(n_ur), 64'(EXP_UR));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/i2s_ser.md
Name: i2s_ser

Overview:
- I2S master transmitter; the counterpart of the I2S deserializer.
- Takes 64-bit parallel stereo samples (high word left, low word right) through a valid/ready handshake.
- Regenerates a standard I2S stream (BCK, LRCK, DATA) derived from the master clock.
- Sits between the sample-processing path and the DAC serial data outputs, muxed with the MCU pass-through I2S path.

Parameters:
MCLK_PER_BCK, 4, clk cycles per BCK period; even, >=2.
FRAME_BITS, 64, BCK periods per stereo frame; fixed, 32 slots per channel; documented constant, not overridable.

Ports:
clk  input  1  master clock (mclk domain)
reset  input  1  asynchronous, active-high reset
enable  input  1  run request; sampled at frame boundaries only
bitnum  input  BITNUM  sample width b16/b24/b32; sampled at frame load
in_data  input  64  [63:32] left, [31:0] right; each MSB-aligned in its 32-bit half
in_valid  input  1  in_data valid
in_ready  output  1  holding buffer empty; a transfer occurs when in_valid && in_ready
i2s_bck  output  1  bit clock
i2s_lrck  output  1  word select; 0 = left, 1 = right
i2s_data  output  1  serial data, MSB first
frame_start  output  1  one-clk pulse when a frame is loaded into the shifter
underrun  output  1  one-clk pulse when a frame boundary finds the buffer empty

Behaviour:
- Reset values: i2s_bck=0, i2s_lrck=0, i2s_data=0, in_ready=1, frame_start=0, underrun=0; buffer empty; state IDLE; div_cnt=0; bit_cnt=63. All outputs are registered.
- Holding buffer: one entry, 64 bits. in_ready = !buf_full. On transfer, buf_full is set and in_ready falls the next clk. buf_full clears when the shifter loads from it.
- div_cnt counts 0..MCLK_PER_BCK-1 in RUN. i2s_bck=0 while div_cnt < MCLK_PER_BCK/2, else 1. A BCK falling edge is the div_cnt wrap to 0.
- On each falling edge, bit_cnt increments mod 64, and i2s_data/i2s_lrck update on that same edge.
- i2s_lrck = 1 for bit_cnt 31..62, 0 for bit_cnt 63 and 0..30. This gives the one-BCK I2S lead before each MSB.
- i2s_data at bit_cnt k: left bit (31-k) for k in 0..31; right bit (63-k) for k in 32..63.
- Frame load occurs on the falling edge where bit_cnt wraps 63->0:
  - buffer full: shifter <= buffer with bitnum mask applied to each half. b16 zeroes bits [15:0] of each half, b24 zeroes [7:0], b32 applies no mask. Buffer is cleared; frame_start pulses.
  - buffer empty: shifter <= 0 (silence) and underrun pulses.
- FSM:
  - IDLE: counters held (div_cnt=0, bit_cnt=63); bck/lrck/data = 0. Go to RUN when enable && buf_full.
  - RUN: free-running. At the 63->0 wrap with enable=0, go to IDLE instead of loading; the buffer is retained and the last frame completes in full.
- Latency: the left MSB appears on i2s_data MCLK_PER_BCK clks after entering RUN.
- Simultaneous in_valid and load: impossible while full, because in_ready=0. When the buffer is empty at load, a transfer in the same clk fills it for the next frame; the current frame still underruns.
- enable toggling mid-frame has no effect until the frame boundary.
- bitnum changes mid-frame take effect at the next load.
- Reset mid-operation: immediate return to reset values; partial frame and buffer are discarded.

Optional Feature:
- Macro I2S_SER_UNDERRUN_CNT_EN.
- Defined: adds output underrun_cnt [15:0]. It increments on each underrun pulse, saturates at 16'hFFFF, and is cleared by reset or by a rising edge of enable.
- Undefined: the port and counter are absent; the underrun pulse is unaffected.

Decomposition:
- Package common: reuse the BITNUM enum. Add I2S_FRAME_BITS=64, I2S_SLOT_BITS=32, and typedef I2S_SER_STATE {IDLE, RUN}.
- Sub-module i2s_bck_gen (div_cnt, bck, falling-edge strobe) is natural and reusable by the NOS transceiver. The shifter/FSM stays in i2s_ser.

Test Plan (MCLK_PER_BCK=4, frame = 256 clk):
- Reset, then enable=1, push 64'hA5A5_0000_0000_5A5A with b32 -> lrck low, left bits 0xA5A50000 MSB first, then lrck high with 0x00005A5A; frame_start once; in_ready=1 by the next clk after load.
- b16 with in_data 64'h1234_FFFF_ABCD_FFFF -> serialized left 0x12340000 and right 0xABCD0000; the lrck edge precedes each MSB by exactly 4 clk.
- Feed one sample, then hold in_valid=0 -> the second frame is all-zero data, underrun pulses once at clk 256 after the first load, and bck/lrck keep running.
- Deassert enable at bit_cnt 10 -> the frame completes through bit 63, then IDLE with all outputs 0; a buffered sample stays held (in_ready=0).
- Assert reset at bit_cnt 40 -> all outputs take reset values on the same cycle (asynchronous); in_ready=1.
- With I2S_SER_UNDERRUN_CNT_EN, starve for 3 frames -> underrun_cnt=3; toggling enable 0->1 clears it to 0.
